audio_sink_fifo: RTL and testbench
==================================

Name: audio_sink_fifo

Overview:
- Consumer end of the sample-player handshake: asserts `audio_out_allowed`, accepts `audio_out` samples on `write_audio_out`, and flushes on `clear_buffer`.
- Buffers samples in a small FIFO and serialises them to an external DAC as a mono, left-justified, two-slot frame. The same sample goes to both channels.
- Sits between the sound-player mux and the board audio codec pins.

Parameters:
- DATA_W, 10, sample width; matches `audio_out`.
- DEPTH, 16, FIFO entries; must be a power of 2, ≥ 2.
- CLK_DIV, 4, system clocks per `bclk` half-period; ≥ 1.
- SLOT_W, 16, `bclk` periods per channel slot; ≥ DATA_W.

Ports:
- clock  in  1  system clock; all logic on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- write_audio_out  in  1  push request.
- audio_out  in  DATA_W  sample to push, two's complement.
- clear_buffer  in  1  synchronous FIFO flush.
- audio_out_allowed  out  1  FIFO can accept a push this cycle.
- fifo_level  out  $clog2(DEPTH)+1  current FIFO occupancy.
- bclk  out  1  serial bit clock.
- lrck  out  1  channel select; 0 = left slot, 1 = right slot.
- sdata  out  1  serial data, MSB first.
- underflow  out  1  one-cycle pulse when a frame starts with the FIFO empty.

Behaviour:
- Reset values (asynchronous, while `resetn`=0):
  - FIFO pointers and count = 0.
  - `audio_out_allowed`=1, `fifo_level`=0.
  - `bclk`=0, `lrck`=1, `sdata`=0, `underflow`=0.
  - Divider counter = 0.
  - `bit_cnt` = 2*SLOT_W-1.
  - Sample register = 0.
- Handshake:
  - `audio_out_allowed` = (count < DEPTH), decoded from registered count.
  - Push accepted iff `write_audio_out` && `audio_out_allowed`.
  - A write while full is dropped silently; count is unchanged.
  - Accepted data is visible to a pop from the next cycle.
- Divider and bit clock:
  - The divider counts 0..CLK_DIV-1.
  - When it is at CLK_DIV-1 it wraps to 0 and `bclk` toggles.
  - A toggle 1→0 is a falling event.
- On each falling event:
  - `bit_cnt` increments modulo 2*SLOT_W.
  - `lrck` = (new `bit_cnt` ≥ SLOT_W).
  - `sdata` updates per the rule below. Data changes only on falling events; the DAC samples on rising edges.
- Frame start: the falling event where `bit_cnt` wraps to 0.
  - If count > 0: pop the head into the sample register.
  - If count = 0: load 0 into the sample register and pulse `underflow` in the same cycle.
- `sdata` rule, with s = `bit_cnt` mod SLOT_W:
  - s < DATA_W: `sdata` = sample[DATA_W-1-s].
  - otherwise: `sdata` = 0.
  - At frame start, `sdata` uses the newly loaded sample.
- Frame timing: one frame = 2*SLOT_W*2*CLK_DIV clocks (256 with defaults). The first frame start is 2*CLK_DIV clocks after reset release.
- Same-cycle push and pop: count unchanged; both pointers advance.
  - Push while full is not accepted, even if a pop occurs that cycle.
  - Pop while empty cannot occur; the empty case is handled as underflow.
- `clear_buffer`:
  - Pointers and count go to 0 next cycle.
  - `clear_buffer` overrides a same-cycle push (push dropped) and a same-cycle pop; that frame is treated as underflow.
  - The serializer, divider and current sample are not affected.
- `fifo_level` = registered count, range 0..DEPTH.
- Reset asserted mid-frame: everything returns to reset values immediately, asynchronously.

Optional Feature:
- Macro: AUDIO_SINK_HOLD_EN.
- Defined: on underflow, the sample register keeps its previous value (the last sample repeats). The `underflow` pulse is unchanged.
- Undefined: on underflow, the sample register loads 0 (silence).
- After reset, both variants hold 0.

Test Plan:
- Reset, then no writes -> `underflow` pulses at clock 8 and every 256 clocks after; `sdata` stays 0; `lrck` toggles every 128 clocks.
- Push 0x2A5, then wait -> at the next frame start the left slot `sdata` bits are 1,0,1,0,1,0,0,1,0,1 then six 0s; the right slot is identical; `fifo_level` goes 1→0 at the pop.
- Push 20 back-to-back samples with `write_audio_out` held high -> first 16 accepted; `audio_out_allowed`=0 once `fifo_level`=16; the remaining 4 are dropped; `fifo_level` stays 16 until the next frame start.
- With FIFO full, assert `write_audio_out` in the same cycle as a frame-start pop -> push rejected; `fifo_level` goes 16→15.
- Fill 5 entries, then assert `clear_buffer` together with `write_audio_out` -> `fifo_level`=0 next cycle; the next frame start pulses `underflow`; the in-progress slot finishes unchanged.
- Push 0x1FF, let it play, then starve the FIFO -> `sdata` is 0 in the next frame without AUDIO_SINK_HOLD_EN, and repeats 0x1FF with it; `underflow` pulses in both builds.

Source files
------------

// File: rtl/audio_sink_fifo.sv
// audio_sink_fifo: consumer end of the sample-player handshake.
// Buffers pushed samples in a small FIFO and serialises one sample per frame
// to an external DAC as a mono, left-justified, two-slot (left/right) frame.
//
// Ports:
//   clock, resetn        system clock (rising edge), async active-low reset
//   write_audio_out      push request
//   audio_out            sample to push (two's complement, DATA_W bits)
//   clear_buffer         synchronous FIFO flush
//   audio_out_allowed    FIFO can accept a push this cycle
//   fifo_level           current FIFO occupancy (0..DEPTH)
//   bclk, lrck, sdata    serial bit clock, channel select (1 = right), data MSB first
//   underflow            one-cycle pulse when a frame starts with nothing to play
//
// Optional build macro AUDIO_SINK_HOLD_EN: on underflow the last sample is
// repeated instead of playing silence.
module audio_sink_fifo #(
    parameter int unsigned DATA_W  = 10,
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned SLOT_W  = 16
) (
    input  logic                     clock,
    input  logic                     resetn,
    input  logic                     write_audio_out,
    input  logic [DATA_W-1:0]        audio_out,
    input  logic                     clear_buffer,
    output logic                     audio_out_allowed,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     bclk,
    output logic                     lrck,
    output logic                     sdata,
    output logic                     underflow
);

    localparam int unsigned PTR_W      = $clog2(DEPTH);
    localparam int unsigned CNT_W      = PTR_W + 1;
    localparam int unsigned DIV_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned FRAME_BITS = 2 * SLOT_W;
    localparam int unsigned BIT_W      = $clog2(FRAME_BITS);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [DIV_W-1:0]  div_cnt;
    logic [BIT_W-1:0]  bit_cnt;
    logic [DATA_W-1:0] sample;

    logic              tick;
    logic              fall;
    logic              frame_start;
    logic              push;
    logic              pop;
    logic              starve;
    logic [CNT_W-1:0]  count_next;
    logic [BIT_W-1:0]  bit_next;
    logic [BIT_W-1:0]  slot_pos;
    logic [DATA_W-1:0] sample_next;
    logic [DATA_W-1:0] shifted;
    logic              sdata_next;

    assign fifo_level = count;

    // Divider wrap, bclk falling event and frame boundary decode
    always_comb begin
        tick        = (div_cnt == DIV_W'(CLK_DIV - 1));
        fall        = tick && bclk;
        frame_start = fall && (bit_cnt == BIT_W'(FRAME_BITS - 1));
        bit_next    = (bit_cnt == BIT_W'(FRAME_BITS - 1)) ? '0 : bit_cnt + BIT_W'(1);
    end

    // Handshake: a flush wins over both a push and a frame-start pop
    always_comb begin
        push   = write_audio_out && audio_out_allowed && !clear_buffer;
        pop    = frame_start && (count != '0) && !clear_buffer;
        starve = frame_start && !pop;

        count_next = count;
        if (clear_buffer) begin
            count_next = '0;
        end else if (push && !pop) begin
            count_next = count + CNT_W'(1);
        end else if (pop && !push) begin
            count_next = count - CNT_W'(1);
        end
    end

    // Sample selection and serial bit; the frame-start bit uses the new sample
    always_comb begin
        sample_next = sample;
        if (pop) begin
            sample_next = mem[rd_ptr];
        end else if (starve) begin
`ifdef AUDIO_SINK_HOLD_EN
            sample_next = sample;
`else
            sample_next = '0;
`endif
        end

        slot_pos   = (bit_next >= BIT_W'(SLOT_W)) ? bit_next - BIT_W'(SLOT_W) : bit_next;
        shifted    = sample_next << slot_pos;
        sdata_next = (slot_pos < BIT_W'(DATA_W)) && shifted[DATA_W-1];
    end

    // FIFO storage; no reset needed, reads are gated by count
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= audio_out;
        end
    end

    // FIFO pointers, occupancy and handshake flag
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_ptr            <= '0;
            rd_ptr            <= '0;
            count             <= '0;
            audio_out_allowed <= 1'b1;
        end else begin
            count             <= count_next;
            audio_out_allowed <= (count_next < CNT_W'(DEPTH));
            if (clear_buffer) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
            end
        end
    end

    // Bit-clock divider and serializer
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            div_cnt   <= '0;
            bclk      <= 1'b0;
            bit_cnt   <= BIT_W'(FRAME_BITS - 1);
            lrck      <= 1'b1;
            sdata     <= 1'b0;
            sample    <= '0;
            underflow <= 1'b0;
        end else begin
            div_cnt   <= tick ? '0 : div_cnt + DIV_W'(1);
            sample    <= sample_next;
            underflow <= starve;
            if (tick) begin
                bclk <= ~bclk;
            end
            if (fall) begin
                bit_cnt <= bit_next;
                lrck    <= (bit_next >= BIT_W'(SLOT_W));
                sdata   <= sdata_next;
            end
        end
    end

endmodule

// File: tb/tb_audio_sink_fifo.sv
// Testbench for audio_sink_fifo: a reference model predicts each frame's
// sample and queues it; a monitor deserialises the DAC stream and compares.
module tb_audio_sink_fifo;

    localparam int DATA_W = 10;
    localparam int DEPTH  = 16;
    localparam int FRAME  = 256;
    localparam int FIRST  = 8;

    logic              clock = 1'b0;
    logic              resetn = 1'b0;
    logic              write_audio_out = 1'b0;
    logic [DATA_W-1:0] audio_out = '0;
    logic              clear_buffer = 1'b0;
    logic              audio_out_allowed;
    logic [4:0]        fifo_level;
    logic              bclk;
    logic              lrck;
    logic              sdata;
    logic              underflow;

    audio_sink_fifo dut (
        .clock             (clock),
        .resetn            (resetn),
        .write_audio_out   (write_audio_out),
        .audio_out         (audio_out),
        .clear_buffer      (clear_buffer),
        .audio_out_allowed (audio_out_allowed),
        .fifo_level        (fifo_level),
        .bclk              (bclk),
        .lrck              (lrck),
        .sdata             (sdata),
        .underflow         (underflow)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: FIFO contents, frame timing and per-frame sample
    logic [DATA_W-1:0] ref_q[$];
    logic [DATA_W-1:0] exp_q[$];
    int                m_cyc = 0;
    logic              m_uf = 1'b0;
    int                m_level = 0;
    logic              m_allowed = 1'b1;
    logic [DATA_W-1:0] m_last = '0;
    int                frames_pushed = 0;

    always @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            ref_q.delete();
            m_cyc     = 0;
            m_uf      = 1'b0;
            m_level   = 0;
            m_allowed = 1'b1;
            m_last    = '0;
        end else begin
            bit fs;
            bit acc;
            m_cyc++;
            fs   = ((m_cyc % FRAME) == FIRST);
            acc  = write_audio_out && (ref_q.size() < DEPTH) && !clear_buffer;
            m_uf = 1'b0;
            if (clear_buffer) begin
                ref_q.delete();
                if (fs) begin
                    m_uf = 1'b1;
`ifndef AUDIO_SINK_HOLD_EN
                    m_last = '0;
`endif
                end
            end else begin
                if (fs) begin
                    if (ref_q.size() > 0) begin
                        m_last = ref_q.pop_front();
                    end else begin
                        m_uf = 1'b1;
`ifndef AUDIO_SINK_HOLD_EN
                        m_last = '0;
`endif
                    end
                end
                if (acc) ref_q.push_back(audio_out);
            end
            if (fs) begin
                exp_q.push_back(m_last);
                frames_pushed++;
            end
            m_level   = ref_q.size();
            m_allowed = (m_level < DEPTH);
        end
    end

    // Monitor: per-cycle status checks and frame deserialisation on bclk falls
    int                k = -1;
    logic              prev_bclk = 1'b0;
    logic [31:0]       acc_s = '0;
    logic [31:0]       acc_l = '0;
    logic [DATA_W-1:0] cur = '0;
    int                frames_popped = 0;

    always @(negedge clock) begin
        if (!resetn) begin
            k         = -1;
            prev_bclk = 1'b0;
        end else begin
            check("underflow", 32'(underflow), 32'(m_uf));
            check("fifo_level", 32'(fifo_level), 32'(m_level));
            check("allowed", 32'(audio_out_allowed), 32'(m_allowed));
            if (prev_bclk && !bclk) begin
                if (k < 0 || k == 31) begin
                    k     = 0;
                    acc_s = '0;
                    acc_l = '0;
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL frame_start: got unexpected frame want none at %0t", $time);
                        cur = '0;
                    end else begin
                        cur = exp_q.pop_front();
                        frames_popped++;
                    end
                end else begin
                    k++;
                end
                acc_s = {acc_s[30:0], sdata};
                acc_l = {acc_l[30:0], lrck};
                if (k == 31) begin
                    check("frame_sdata", acc_s, {cur, 6'b0, cur, 6'b0});
                    check("frame_lrck", acc_l, 32'h0000_ffff);
                end
            end
            prev_bclk = bclk;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Leaves the bench one cycle before a frame-start edge
    task automatic to_fs();
        while (((m_cyc + 1) % FRAME) != FIRST) step(1);
    endtask

    task automatic push1(input logic [DATA_W-1:0] d);
        write_audio_out = 1'b1;
        audio_out       = d;
        step(1);
        write_audio_out = 1'b0;
    endtask

    task automatic check_reset_values();
        check("rst_bclk", 32'(bclk), 32'd0);
        check("rst_lrck", 32'(lrck), 32'd1);
        check("rst_sdata", 32'(sdata), 32'd0);
        check("rst_underflow", 32'(underflow), 32'd0);
        check("rst_allowed", 32'(audio_out_allowed), 32'd1);
        check("rst_level", 32'(fifo_level), 32'd0);
    endtask

    initial begin
        step(3);
        check_reset_values();
        resetn = 1'b1;

        // Idle: silent frames, underflow at cycle 8 and every 256 after
        step(600);

        // Single sample 0x2A5 plays in the next frame
        push1(10'h2A5);
        check("level_after_push", 32'(fifo_level), 32'd1);
        step(300);

        // Fill past full right after a frame start
        to_fs();
        step(1);
        write_audio_out = 1'b1;
        for (int i = 0; i < 20; i++) begin
            audio_out = DATA_W'(10'h100 + i);
            step(1);
        end
        write_audio_out = 1'b0;
        check("full_level", 32'(fifo_level), 32'd16);
        check("full_allowed", 32'(audio_out_allowed), 32'd0);

        // Push while full on a frame-start pop is rejected
        to_fs();
        push1(10'h3AA);
        check("fs_full_level", 32'(fifo_level), 32'd15);
        check("fs_full_allowed", 32'(audio_out_allowed), 32'd1);

        // Flush, refill 5, then flush together with a write
        clear_buffer = 1'b1;
        step(1);
        clear_buffer = 1'b0;
        check("clear_level", 32'(fifo_level), 32'd0);
        write_audio_out = 1'b1;
        for (int i = 0; i < 5; i++) begin
            audio_out = DATA_W'(10'h050 + i);
            step(1);
        end
        write_audio_out = 1'b0;
        check("five_level", 32'(fifo_level), 32'd5);
        clear_buffer    = 1'b1;
        write_audio_out = 1'b1;
        audio_out       = 10'h3FF;
        step(1);
        clear_buffer    = 1'b0;
        write_audio_out = 1'b0;
        check("clear_wr_level", 32'(fifo_level), 32'd0);
        to_fs();
        step(1);
        check("clear_underflow", 32'(underflow), 32'd1);

        // 0x1FF plays, then the FIFO starves
        push1(10'h1FF);
        to_fs();
        step(1);
        check("pop_no_underflow", 32'(underflow), 32'd0);
        to_fs();
        step(1);
        check("starve_underflow", 32'(underflow), 32'd1);
        step(300);

        // Flush on the frame-start cycle turns the pop into an underflow
        push1(10'h123);
        to_fs();
        clear_buffer = 1'b1;
        step(1);
        clear_buffer = 1'b0;
        check("clear_fs_underflow", 32'(underflow), 32'd1);
        check("clear_fs_level", 32'(fifo_level), 32'd0);

        // Asynchronous reset in the middle of a frame
        push1(10'h0F0);
        to_fs();
        step(100);
        resetn = 1'b0;
        #1;
        check_reset_values();
        step(2);
        resetn = 1'b1;
        push1(10'h155);
        step(600);

        @(negedge clock);
        #1;
        check("exp_queue_empty", 32'(exp_q.size()), 32'd0);
        check("frame_count", 32'(frames_popped), 32'(frames_pushed));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
